// File: rtl/svm_pkg.sv
// Shared fixed-point defaults and FSM state encoding for the SVM decision-stage accumulator.
package svm_pkg;

  localparam int IN_W_DEF      = 17;
  localparam int ACC_W_DEF     = 22;
  localparam int FRAC_W_DEF    = 13;
  localparam int MAX_TERMS_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/svm_sat_add.sv
// Combinational signed adder that clamps to the W-bit two's-complement range.
module svm_sat_add #(
  parameter int W = 22
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         sat
);

  logic [W:0] full_s;

  assign full_s = {a[W-1], a} + {b[W-1], b};

  // Top two bits of the widened sum disagree exactly when the W-bit result overflowed.
  always_comb begin
    s   = full_s[W-1:0];
    sat = 1'b0;
    if (full_s[W] != full_s[W-1]) begin
      sat = 1'b1;
      if (full_s[W]) begin
        s = {1'b1, {(W-1){1'b0}}};
      end else begin
        s = {1'b0, {(W-1){1'b1}}};
      end
    end else begin
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/svm_frame_acc.sv
// Framed saturating accumulator: bias + sum of terms per frame, result via valid/ready register.
module svm_frame_acc
  import svm_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [ACC_W-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_class,
  output logic             out_sat,
  output logic             out_len_err
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  if (ACC_W <= IN_W || FRAC_W >= IN_W || MAX_TERMS < 1) begin : g_bad_params
    $error("svm_frame_acc: ACC_W must exceed IN_W, FRAC_W must be below IN_W, MAX_TERMS >= 1");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_class_q, out_class_d;
  logic             out_sat_q, out_sat_d;
  logic             out_len_err_q, out_len_err_d;

  logic             beat_s;
  logic             emit_s;
  logic             len_err_s;
  logic [ACC_W-1:0] add_a_s;
  logic [ACC_W-1:0] term_s;
  logic [ACC_W-1:0] sum_s;
  logic             clamp_s;
  logic             sat_next_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // The output register may be refilled only when it is empty or being drained this cycle.
  assign in_ready   = rst & ce & (~out_valid_q | out_ready);
  assign beat_s     = in_valid & in_ready;
  assign term_s     = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign add_a_s    = (state_q == ST_IDLE) ? bias : acc_q;
  assign sat_next_s = (state_q == ST_IDLE) ? clamp_s : (sat_q | clamp_s);
  assign cnt_inc_s  = cnt_q + CNT_W'(1);

  svm_sat_add #(.W(ACC_W)) u_add (
    .a   (add_a_s),
    .b   (term_s),
    .s   (sum_s),
    .sat (clamp_s)
  );

  // Frame FSM: accumulate, emit on last beat or on overlength, then drain the remainder.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    emit_s    = 1'b0;
    len_err_s = 1'b0;
    if (beat_s) begin
      case (state_q)
        ST_IDLE: begin
          acc_d = sum_s;
          cnt_d = CNT_W'(1);
          sat_d = sat_next_s;
          if (in_last) begin
            emit_s  = 1'b1;
            state_d = ST_IDLE;
          end else if (MAX_TERMS == 1) begin
            emit_s    = 1'b1;
            len_err_s = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          acc_d = sum_s;
          cnt_d = cnt_inc_s;
          sat_d = sat_next_s;
          if (in_last) begin
            emit_s  = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_inc_s == CNT_W'(MAX_TERMS)) begin
            emit_s    = 1'b1;
            len_err_s = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_DRAIN: begin
          if (in_last) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Result register: a new emit wins over a same-cycle handoff, keeping out_valid high.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_class_d   = out_class_q;
    out_sat_d     = out_sat_q;
    out_len_err_d = out_len_err_q;
    if (emit_s) begin
      out_valid_d   = 1'b1;
      out_sum_d     = sum_s;
      out_class_d   = ~sum_s[ACC_W-1];
      out_sat_d     = sat_next_s;
      out_len_err_d = len_err_s;
    end else if (ce && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // All state advances only with ce; reset discards any partial frame and pending result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_class_q   <= 1'b0;
      out_sat_q     <= 1'b0;
      out_len_err_q <= 1'b0;
    end else if (ce) begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sat_q         <= sat_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_class_q   <= out_class_d;
      out_sat_q     <= out_sat_d;
      out_len_err_q <= out_len_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_class   = out_class_q;
  assign out_sat     = out_sat_q;
  assign out_len_err = out_len_err_q;

endmodule

// File: tb/tb_svm_frame_acc.sv
// Directed bench: default instance plus a MAX_TERMS=4 instance sharing the same input stream.
module tb_svm_frame_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic signed [21:0] bias;
  logic               in_valid;
  logic signed [16:0] in_data;
  logic               in_last;
  logic               out_ready;

  logic               in_ready, out_valid, out_class, out_sat, out_len_err;
  logic signed [21:0] out_sum;
  logic               d4_in_ready, d4_out_valid, d4_out_class, d4_out_sat, d4_out_len_err;
  logic signed [21:0] d4_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svm_frame_acc dut (
    .clk(clk), .rst(rst), .ce(ce), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_class(out_class), .out_sat(out_sat), .out_len_err(out_len_err)
  );

  svm_frame_acc #(.MAX_TERMS(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .bias(bias),
    .in_valid(in_valid), .in_ready(d4_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(d4_out_valid), .out_ready(out_ready), .out_sum(d4_out_sum),
    .out_class(d4_out_class), .out_sat(d4_out_sat), .out_len_err(d4_out_len_err)
  );

  // Present one beat, wait (bounded) for in_ready, return #1 after the accepting edge.
  task automatic send(input logic signed [16:0] d, input logic l);
    bit got = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; bias = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_sum, out_class, out_sat, out_len_err, in_ready} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b sum=%0d class=%0b sat=%0b len=%0b rdy=%0b required all 0",
               out_valid, out_sum, out_class, out_sat, out_len_err, in_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bias = 22'sd0;
    send(17'sd8192, 1'b0);
    send(17'sd8192, 1'b0);
    send(-17'sd4096, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd12288 || out_class !== 1'b1 ||
        out_sat !== 1'b0 || out_len_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: valid=%0b sum=%0d class=%0b sat=%0b len=%0b required 1/12288/1/0/0",
               out_valid, out_sum, out_class, out_sat, out_len_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_valid: valid=%0b required 0", out_valid);
    end
    bias = -22'sd16384;
    send(17'sd8192, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== -22'sd8192 || out_class !== 1'b0 || out_len_err !== 1'b0) begin
      errors++;
      $display("FAIL single_beat: valid=%0b sum=%0d class=%0b len=%0b required 1/-8192/0/0",
               out_valid, out_sum, out_class, out_len_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bias = 22'sd2097000;
    send(17'sd65535, 1'b0);
    send(17'sd65535, 1'b0);
    send(17'sd65535, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd2097151 || out_sat !== 1'b1 || out_class !== 1'b1) begin
      errors++;
      $display("FAIL sat_clamp: valid=%0b sum=%0d sat=%0b class=%0b required 1/2097151/1/1",
               out_valid, out_sum, out_sat, out_class);
    end
    bias = 22'sd0;
    send(17'sd1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd1 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_cleared: valid=%0b sum=%0d sat=%0b required 1/1/0", out_valid, out_sum, out_sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len_err();
    bias = 22'sd100;
    for (int i = 0; i < 4; i++) send(17'sd1, 1'b0);
    checks++;
    if (d4_out_valid !== 1'b1 || d4_out_sum !== 22'sd104 || d4_out_len_err !== 1'b1 || d4_out_sat !== 1'b0) begin
      errors++;
      $display("FAIL len_err_emit: valid=%0b sum=%0d len=%0b sat=%0b required 1/104/1/0",
               d4_out_valid, d4_out_sum, d4_out_len_err, d4_out_sat);
    end
    send(17'sd1, 1'b0);
    send(17'sd1, 1'b1);
    checks++;
    if (d4_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL len_err_drain: valid=%0b required 0", d4_out_valid);
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd106 || out_len_err !== 1'b0) begin
      errors++;
      $display("FAIL len_full_frame: valid=%0b sum=%0d len=%0b required 1/106/0", out_valid, out_sum, out_len_err);
    end
    bias = 22'sd0;
    send(17'sd2, 1'b0);
    send(17'sd3, 1'b1);
    checks++;
    if (d4_out_valid !== 1'b1 || d4_out_sum !== 22'sd5 || d4_out_len_err !== 1'b0) begin
      errors++;
      $display("FAIL len_next_frame: valid=%0b sum=%0d len=%0b required 1/5/0",
               d4_out_valid, d4_out_sum, d4_out_len_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    bias = 22'sd0;
    out_ready = 1'b0;
    send(17'sd10, 1'b1);
    in_valid = 1'b1; in_data = 17'sd20; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 22'sd10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable: %0d bad cycles (rdy=%0b valid=%0b sum=%0d) required 0/1/10",
               bad, in_ready, out_valid, out_sum);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd20) begin
      errors++;
      $display("FAIL handoff: valid=%0b sum=%0d required 1/20", out_valid, out_sum);
    end
    for (int k = 0; k < 3; k++) begin
      in_data = 17'(30 + 10 * k);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 22'(30 + 10 * k)) begin
        errors++;
        $display("FAIL stream_%0d: valid=%0b sum=%0d required 1/%0d", k, out_valid, out_sum, 30 + 10 * k);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset_ce();
    out_ready = 1'b0;
    bias = 22'sd0;
    send(17'sd7, 1'b1);
    rst = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 22'sd0 || out_class !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending: valid=%0b sum=%0d class=%0b required 0/0/0", out_valid, out_sum, out_class);
    end
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(17'sd5, 1'b0);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send(17'sd9, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd9) begin
      errors++;
      $display("FAIL reset_midframe: valid=%0b sum=%0d required 1/9", out_valid, out_sum);
    end
    @(posedge clk); #1;
    send(17'sd4, 1'b0);
    send(17'sd4, 1'b0);
    ce = 1'b0;
    in_valid = 1'b1; in_data = 17'sd100; in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ce_freeze: rdy=%0b valid=%0b required 0/0", in_ready, out_valid);
    end
    in_valid = 1'b0; in_last = 1'b0; ce = 1'b1;
    send(17'sd4, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd12) begin
      errors++;
      $display("FAIL ce_sum: valid=%0b sum=%0d required 1/12", out_valid, out_sum);
    end
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 22'sd12) begin
      errors++;
      $display("FAIL ce_hold_out: valid=%0b sum=%0d required 1/12", out_valid, out_sum);
    end
    ce = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_beat();
    test_saturation();
    test_len_err();
    test_back_to_back();
    test_reset_ce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
